// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register bank: NUM_REGS read/write registers of DATA_BIT_WIDTH
// bits, with byte strobes, an OKAY/SLVERR address decode and a parallel copy of
// every register for fabric logic.
//
// Ports:
//   clk, sync_rst            clock (rising edge) and synchronous active-high reset
//   aw*/w*/b*                write address, write data and write response channels
//   ar*/r*                   read address and read data channels
//   awprot, arprot           accepted but ignored
//   regs_out                 reg i at [i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH]
module axi4_lite_slv_reg_file #(
  parameter int unsigned ADDR_BIT_WIDTH = 32,
  parameter int unsigned DATA_BIT_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 4
) (
  input  logic                               clk,
  input  logic                               sync_rst,
  input  logic [ADDR_BIT_WIDTH-1:0]          awaddr,
  input  logic [2:0]                         awprot,
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [DATA_BIT_WIDTH-1:0]          wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]        wstrb,
  input  logic                               wvalid,
  output logic                               wready,
  output logic [1:0]                         bresp,
  output logic                               bvalid,
  input  logic                               bready,
  input  logic [ADDR_BIT_WIDTH-1:0]          araddr,
  input  logic [2:0]                         arprot,
  input  logic                               arvalid,
  output logic                               arready,
  output logic [DATA_BIT_WIDTH-1:0]          rdata,
  output logic [1:0]                         rresp,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] regs_out
);

  localparam int unsigned STRB_W    = DATA_BIT_WIDTH / 8;
  localparam int unsigned ADDR_OFFS = $clog2(STRB_W);
  localparam int unsigned IDX_W     = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic [DATA_BIT_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_BIT_WIDTH-1:0] regs_d [NUM_REGS];
  logic                      awready_q, awready_d;
  logic                      bvalid_q, bvalid_d;
  resp_e                     bresp_q, bresp_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  resp_e                     rresp_q, rresp_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;

  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Any set bit above the word index makes the access out of range.
  assign wr_in_range = (awaddr >> ADDR_OFFS) < ADDR_BIT_WIDTH'(NUM_REGS);
  assign rd_in_range = (araddr >> ADDR_OFFS) < ADDR_BIT_WIDTH'(NUM_REGS);
  assign wr_idx      = awaddr[ADDR_OFFS +: IDX_W];
  assign rd_idx      = araddr[ADDR_OFFS +: IDX_W];

  // Write path: awready/wready share one flop and pulse for a single cycle;
  // the edge that ends that cycle commits the data and raises bvalid.
  always_comb begin
    regs_d    = regs_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awready_d = awvalid & wvalid & ~awready_q & ~bvalid_q;
    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
    if (awready_q) begin
      bvalid_d = 1'b1;
      if (wr_in_range) begin
        bresp_d = RESP_OKAY;
        for (int unsigned k = 0; k < STRB_W; k++) begin
          if (wstrb[k]) begin
            regs_d[wr_idx][k*8 +: 8] = wdata[k*8 +: 8];
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
  end

  // Read path samples regs_q, so a read committing on the same edge as a
  // write to the same register returns the pre-write value.
  always_comb begin
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_d = arvalid & ~arready_q & ~rvalid_q;
    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    if (arready_q) begin
      rvalid_d = 1'b1;
      if (rd_in_range) begin
        rdata_d = regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs_q[i];
    end
  end

  assign awready = awready_q;
  assign wready  = awready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Self-checking bench for axi4_lite_slv_reg_file (32-bit data, 4 registers):
// a table of directed write/read vectors plus hand-written sequences for
// backpressure, channel skew, same-edge read/write and mid-transaction reset.
module tb_axi4_lite_slv_reg_file;

  logic         clk = 1'b0;
  logic         sync_rst;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [127:0] regs_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_slv_reg_file #(
    .ADDR_BIT_WIDTH(32),
    .DATA_BIT_WIDTH(32),
    .NUM_REGS(4)
  ) dut (
    .clk(clk), .sync_rst(sync_rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out)
  );

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int idx);
    return regs_out[idx*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aw();
    for (int i = 0; i < 20; i++) begin
      step();
      if (awready) break;
    end
  endtask

  task automatic wait_ar();
    for (int i = 0; i < 20; i++) begin
      step();
      if (arready) break;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    chk("wr_awready", {31'b0, awready}, 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    araddr = a; arvalid = 1'b1;
    wait_ar();
    chk("rd_arready", {31'b0, arready}, 32'd1);
    step();
    arvalid = 1'b0;
    chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    //            wr    addr          data          strb  resp   rdata
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 2'b00, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'h11223344, 4'h5, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 2'b00, 32'hDE22BE44};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 2'b10, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 2'b00, 32'hDE22BE44};
    vecs[8]  = '{1'b1, 32'h0000_000E, 32'hA5A5A5A5, 4'hC, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,        4'h0, 2'b00, 32'hA5A50000};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, 2'b00, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h8000_0004, 32'h0,        4'h0, 2'b10, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 2'b00, 32'h0000_0000};

    sync_rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b0;

    chk("rst_ready_valid", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    chk("rst_resp_bits", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_reg%0d", i), reg_at(i), 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("v%0d_bresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
      end else begin
        do_read(vecs[i].addr, d, r);
        chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
        chk($sformatf("v%0d_rresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
      end
    end
    chk("tbl_reg0", reg_at(0), 32'h0000_0000);
    chk("tbl_reg1", reg_at(1), 32'hDE22BE44);
    chk("tbl_reg2", reg_at(2), 32'h0000_0000);
    chk("tbl_reg3", reg_at(3), 32'hA5A50000);

    // Write backpressure: bready low for 5 cycles with a second write pending.
    awaddr = 32'h0; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    chk("bp_w_awready", {31'b0, awready}, 32'd1);
    step();
    chk("bp_w_reg0", reg_at(0), 32'h0BADF00D);
    awaddr = 32'h8; wdata = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_w_hold%0d", i), {29'b0, bvalid, bresp}, 32'b100);
      chk($sformatf("bp_w_noacc%0d", i), {31'b0, awready}, 32'd0);
      step();
    end
    bready = 1'b1;
    step();
    chk("bp_w_bclear", {31'b0, bvalid}, 32'd0);
    bready = 1'b0;
    wait_aw();
    chk("bp_w2_awready", {31'b0, awready}, 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_w2_bvalid", {29'b0, bvalid, bresp}, 32'b100);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bp_w2_reg2", reg_at(2), 32'h0000_0077);

    // Read backpressure: rready low for 5 cycles with a second read pending.
    araddr = 32'h0; arvalid = 1'b1;
    wait_ar();
    chk("bp_r_arready", {31'b0, arready}, 32'd1);
    step();
    araddr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_r_hold%0d", i), {29'b0, rvalid, rresp}, 32'b100);
      chk($sformatf("bp_r_data%0d", i), rdata, 32'h0BADF00D);
      chk($sformatf("bp_r_noacc%0d", i), {31'b0, arready}, 32'd0);
      step();
    end
    rready = 1'b1;
    step();
    chk("bp_r_rclear", {31'b0, rvalid}, 32'd0);
    rready = 1'b0;
    wait_ar();
    step();
    arvalid = 1'b0;
    chk("bp_r2_rvalid", {31'b0, rvalid}, 32'd1);
    chk("bp_r2_rdata", rdata, 32'h0000_0077);
    rready = 1'b1;
    step();
    rready = 1'b0;

    // Channel skew: awvalid leads wvalid by 3 cycles.
    awaddr = 32'hC; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("skew_wait%0d", i), {30'b0, awready, wready}, 32'd0);
    end
    chk("skew_reg3_old", reg_at(3), 32'hA5A50000);
    wvalid = 1'b1;
    wait_aw();
    chk("skew_ready_pair", {30'b0, awready, wready}, 32'b11);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("skew_bvalid", {29'b0, bvalid, bresp}, 32'b100);
    bready = 1'b1;
    step();
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("skew_once%0d", i), {30'b0, awready, bvalid}, 32'd0);
      step();
    end
    chk("skew_reg3", reg_at(3), 32'h5A5A5A5A);

    // Same-edge write and read of reg1: read sees the pre-write value.
    awaddr = 32'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1;
    wait_aw();
    chk("same_ready_pair", {30'b0, awready, arready}, 32'b11);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_rdata", rdata, 32'hDE22BE44);
    chk("same_valids", {30'b0, bvalid, rvalid}, 32'b11);
    chk("same_reg1", reg_at(1), 32'hCAFEF00D);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;

    // Reset during the handshake cycle drops the write.
    awaddr = 32'h8; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    sync_rst = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; sync_rst = 1'b0;
    chk("midrst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("midrst_reg2", reg_at(2), 32'd0);
    step();
    chk("midrst_after", {30'b0, bvalid, awready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
